// File: rtl/bus_mux.sv
// bus_mux: registered 15-source data-bus selector with one-hot source tag
module bus_mux #(
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [3:0]        mux_sel,
   input  logic [DATA_W-1:0] MEM,
   input  logic [DATA_W-1:0] AR,
   input  logic [DATA_W-1:0] DR,
   input  logic [DATA_W-1:0] RP,
   input  logic [DATA_W-1:0] RT,
   input  logic [DATA_W-1:0] RM1,
   input  logic [DATA_W-1:0] RK1,
   input  logic [DATA_W-1:0] RN1,
   input  logic [DATA_W-1:0] RM2,
   input  logic [DATA_W-1:0] RK2,
   input  logic [DATA_W-1:0] RN2,
   input  logic [DATA_W-1:0] C1,
   input  logic [DATA_W-1:0] C2,
   input  logic [DATA_W-1:0] C3,
   input  logic [DATA_W-1:0] AC,
   output logic [DATA_W-1:0] Bus_select,
   output logic [14:0]       Bus_src
);
   logic [DATA_W-1:0] src [16];
   logic [DATA_W-1:0] bus_nxt;
   logic [14:0]       src_nxt;
   // Source table indexed by select code; slot 15 is the idle all-zero value
   always_comb begin
      src[0]  = MEM;
      src[1]  = AR;
      src[2]  = DR;
      src[3]  = RP;
      src[4]  = RT;
      src[5]  = RM1;
      src[6]  = RK1;
      src[7]  = RN1;
      src[8]  = RM2;
      src[9]  = RK2;
      src[10] = RN2;
      src[11] = C1;
      src[12] = C2;
      src[13] = C3;
      src[14] = AC;
      src[15] = '0;
   end
   assign bus_nxt = src[mux_sel];
   assign src_nxt = (mux_sel == 4'hF) ? 15'd0 : 15'd1 << mux_sel;
   // Bus output register, refreshed every edge, cleared asynchronously
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Bus_select <= '0;
         Bus_src    <= '0;
      end else begin
         Bus_select <= bus_nxt;
         Bus_src    <= src_nxt;
      end
   end
endmodule

// File: tb/tb_bus_mux.sv
// tb_bus_mux: self-checking bench for bus_mux against a one-cycle-delayed reference
module tb_bus_mux;
   logic       Clk = 1'b0;
   logic       Rst_n = 1'b1;
   logic [3:0] mux_sel = 4'hF;
   logic [7:0] s [15];
   logic [7:0] Bus_select;
   logic [14:0] Bus_src;
   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   bus_mux #(.DATA_W(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .mux_sel(mux_sel),
      .MEM(s[0]), .AR(s[1]), .DR(s[2]), .RP(s[3]), .RT(s[4]),
      .RM1(s[5]), .RK1(s[6]), .RN1(s[7]), .RM2(s[8]), .RK2(s[9]),
      .RN2(s[10]), .C1(s[11]), .C2(s[12]), .C3(s[13]), .AC(s[14]),
      .Bus_select(Bus_select), .Bus_src(Bus_src)
   );

   function automatic logic [7:0] ref_bus(input logic [3:0] sel);
      return (sel == 4'd15) ? 8'h00 : s[sel];
   endfunction

   function automatic logic [14:0] ref_src(input logic [3:0] sel);
      logic [14:0] r;
      r = '0;
      if (sel != 4'd15) r[sel] = 1'b1;
      return r;
   endfunction

   task automatic randomize_sources();
      for (int i = 0; i < 15; i++) s[i] = 8'($urandom);
   endtask

   task automatic edge_sample();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      randomize_sources();
      mux_sel = 4'($urandom);
      #2;
      Rst_n = 1'b0;
      #1;
      checks++;
      if (Bus_select !== 8'h00 || Bus_src !== 15'd0) begin
         errors++;
         $display("FAIL reset_async bus=%h src=%h required 00/0000", Bus_select, Bus_src);
      end
      repeat (3) edge_sample();
      checks++;
      if (Bus_select !== 8'h00 || Bus_src !== 15'd0) begin
         errors++;
         $display("FAIL reset_hold bus=%h src=%h required 00/0000", Bus_select, Bus_src);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 15; i++) begin
         @(negedge Clk);
         for (int j = 0; j < 15; j++) s[j] = 8'h10 + 8'(j);
         mux_sel = 4'(i);
         edge_sample();
         checks++;
         if (Bus_select !== 8'h10 + 8'(i) || Bus_src !== 15'(1 << i)) begin
            errors++;
            $display("FAIL sweep_%0d bus=%h src=%h required %h/%h", i, Bus_select, Bus_src,
                     8'h10 + 8'(i), 15'(1 << i));
         end
      end
   endtask

   task automatic test_idle();
      @(negedge Clk);
      for (int i = 0; i < 15; i++) s[i] = 8'hFF;
      mux_sel = 4'd15;
      edge_sample();
      checks++;
      if (Bus_select !== 8'h00 || Bus_src !== 15'd0) begin
         errors++;
         $display("FAIL idle bus=%h src=%h required 00/0000", Bus_select, Bus_src);
      end
   endtask

   task automatic test_latency();
      @(negedge Clk);
      s[0] = 8'h00;
      mux_sel = 4'd0;
      edge_sample();
      @(negedge Clk);
      s[14] = 8'h5A;
      mux_sel = 4'd14;
      #1;
      checks++;
      if (Bus_select !== 8'h00 || Bus_src !== 15'h0001) begin
         errors++;
         $display("FAIL latency_before bus=%h src=%h required 00/0001", Bus_select, Bus_src);
      end
      edge_sample();
      checks++;
      if (Bus_select !== 8'h5A || Bus_src !== 15'h4000) begin
         errors++;
         $display("FAIL latency_after bus=%h src=%h required 5a/4000", Bus_select, Bus_src);
      end
      @(negedge Clk);
      s[14] = 8'hA5;
      #1;
      checks++;
      if (Bus_select !== 8'h5A) begin
         errors++;
         $display("FAIL latency_change_before bus=%h required 5a", Bus_select);
      end
      edge_sample();
      checks++;
      if (Bus_select !== 8'hA5 || Bus_src !== 15'h4000) begin
         errors++;
         $display("FAIL latency_change_after bus=%h src=%h required a5/4000", Bus_select, Bus_src);
      end
   endtask

   task automatic test_isolation();
      @(negedge Clk);
      mux_sel = 4'd2;
      s[2] = 8'h3C;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clk);
         randomize_sources();
         s[2] = 8'h3C;
         edge_sample();
         checks++;
         if (Bus_select !== 8'h3C || Bus_src !== 15'h0004) begin
            errors++;
            $display("FAIL isolation_%0d bus=%h src=%h required 3c/0004", k, Bus_select, Bus_src);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge Clk);
      mux_sel = 4'd5;
      s[5] = 8'hC3;
      edge_sample();
      checks++;
      if (Bus_select !== 8'hC3 || Bus_src !== 15'h0020) begin
         errors++;
         $display("FAIL async_preload bus=%h src=%h required c3/0020", Bus_select, Bus_src);
      end
      #2;
      Rst_n = 1'b0;
      #1;
      checks++;
      if (Bus_select !== 8'h00 || Bus_src !== 15'd0) begin
         errors++;
         $display("FAIL async_assert bus=%h src=%h required 00/0000", Bus_select, Bus_src);
      end
      @(negedge Clk);
      #2;
      Rst_n = 1'b1;
      #1;
      checks++;
      if (Bus_select !== 8'h00 || Bus_src !== 15'd0) begin
         errors++;
         $display("FAIL async_release_hold bus=%h src=%h required 00/0000", Bus_select, Bus_src);
      end
      edge_sample();
      checks++;
      if (Bus_select !== 8'hC3 || Bus_src !== 15'h0020) begin
         errors++;
         $display("FAIL async_reload bus=%h src=%h required c3/0020", Bus_select, Bus_src);
      end
   endtask

   task automatic test_random();
      logic [7:0]  eb;
      logic [14:0] es;
      int bad = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge Clk);
         randomize_sources();
         mux_sel = 4'($urandom);
         eb = ref_bus(mux_sel);
         es = ref_src(mux_sel);
         edge_sample();
         checks++;
         if (Bus_select !== eb || Bus_src !== es) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_%0d sel=%0d bus=%h src=%h required %h/%h", k, mux_sel,
                        Bus_select, Bus_src, eb, es);
         end
      end
   endtask

   initial begin
      randomize_sources();
      test_reset();
      test_sweep();
      test_idle();
      test_latency();
      test_isolation();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
